// File: rtl/ps2_kbmat.sv
// ps2_kbmat: PS/2 keyboard (scan-code set 2) to 64-bit Z88 key matrix.
//   Deserialises PS/2 frames, decodes make/break/prefix sequences and keeps
//   one pressed bit per matrix position (bit 8*c+r, 1 = pressed).
// Ports:
//   mck      master clock (9.83 MHz)
//   res      synchronous active-high reset
//   ps2_clk  raw PS/2 clock pin (asynchronous)
//   ps2_dat  raw PS/2 data pin (asynchronous)
//   kbmat    key matrix, 1 = pressed
//   rx_byte  last good received byte
//   rx_valid one-cycle pulse when rx_byte updates
//   ps2_err  one-cycle pulse on start/parity/stop/timeout error
// Build option: define PS2_KBMAT_EXT_EN to decode E0-prefixed (arrow) keys;
//   otherwise E0 sequences are swallowed without touching kbmat.
//
// Receiver states:  state    | meaning
//                   R_IDLE   | waiting for start bit
//                   R_DATA   | shifting 8 data bits, LSB first
//                   R_PARITY | sampling odd-parity bit
//                   R_STOP   | sampling stop bit, commit or reject byte
// Decoder states:   D_BASE   | plain code = make
//                   D_BRK    | after F0, next code = break
//                   D_EXT    | after E0, extended make or F0
//                   D_EXTBRK | after E0 F0, extended break
//                   D_SKIP   | swallowing the rest of the Pause sequence
module ps2_kbmat #(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 9830
) (
  input  logic        mck,
  input  logic        res,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [63:0] kbmat,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        ps2_err
);
  localparam int CW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_PARITY, R_STOP} rx_state_t;
  typedef enum logic [2:0] {D_BASE, D_BRK, D_EXT, D_EXTBRK, D_SKIP} dec_state_t;

  logic [1:0]    clk_s, dat_s;
  logic          clk_f, dat_f, clk_fd;
  logic [CW-1:0] clk_cnt, dat_cnt;
  logic          fall;

  rx_state_t     rx_state, rx_next;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic          par_ok;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, frame_ok, frame_err;

  dec_state_t    dec_state, dec_next;
  logic [2:0]    skip_cnt;
  logic          skip_load, skip_dec;
  logic          do_set, do_clr, do_clr_all;
  logic [5:0]    bit_idx;
  logic [6:0]    base_lu, ext_lu;

  // Synchronisers and glitch filters; lines idle high.
  always_ff @(posedge mck) begin
    if (res) begin
      clk_s <= 2'b11; dat_s <= 2'b11;
      clk_f <= 1'b1;  dat_f <= 1'b1; clk_fd <= 1'b1;
      clk_cnt <= '0;  dat_cnt <= '0;
    end else begin
      clk_s  <= {clk_s[0], ps2_clk};
      dat_s  <= {dat_s[0], ps2_dat};
      clk_fd <= clk_f;
      if (clk_s[1] == clk_f) clk_cnt <= '0;
      else if (clk_cnt == CW'(FILT_LEN - 1)) begin clk_f <= clk_s[1]; clk_cnt <= '0; end
      else clk_cnt <= clk_cnt + CW'(1);
      if (dat_s[1] == dat_f) dat_cnt <= '0;
      else if (dat_cnt == CW'(FILT_LEN - 1)) begin dat_f <= dat_s[1]; dat_cnt <= '0; end
      else dat_cnt <= dat_cnt + CW'(1);
    end
  end

  assign fall    = clk_fd & ~clk_f;
  assign tmo_hit = (rx_state != R_IDLE) && !fall && (tmo_cnt == '0);

  always_comb begin
    rx_next   = rx_state;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    if (tmo_hit) begin
      rx_next   = R_IDLE;
      frame_err = 1'b1;
    end else if (fall) begin
      case (rx_state)
        R_IDLE:   if (!dat_f) rx_next = R_DATA; else frame_err = 1'b1;
        R_DATA:   if (bit_cnt == 3'd7) rx_next = R_PARITY;
        R_PARITY: rx_next = R_STOP;
        R_STOP: begin
          rx_next = R_IDLE;
          if (dat_f && par_ok) frame_ok = 1'b1;
          else frame_err = 1'b1;
        end
        default:  rx_next = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (res) begin
      rx_state <= R_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      par_ok   <= 1'b0;
      tmo_cnt  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      ps2_err  <= 1'b0;
    end else begin
      rx_state <= rx_next;
      rx_valid <= frame_ok;
      ps2_err  <= frame_err;
      if (frame_ok) rx_byte <= shift;
      // Down-counter reloaded on every edge; expiry means the host stalled.
      if (fall) tmo_cnt <= TW'(TIMEOUT - 1);
      else if (rx_state != R_IDLE && tmo_cnt != '0) tmo_cnt <= tmo_cnt - TW'(1);
      if (fall && rx_state == R_IDLE) bit_cnt <= '0;
      if (fall && rx_state == R_DATA) begin
        shift   <= {dat_f, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fall && rx_state == R_PARITY) par_ok <= ^{shift, dat_f};
    end
  end

  // Keymap: {hit, matrix index}.
  always_comb begin
    case (rx_byte)
      8'h1C:   base_lu = {1'b1, 6'd36};
      8'h29:   base_lu = {1'b1, 6'd62};
      8'h12:   base_lu = {1'b1, 6'd54};
      8'h59:   base_lu = {1'b1, 6'd63};
      8'h66:   base_lu = {1'b1, 6'd7};
      8'h5A:   base_lu = {1'b1, 6'd6};
      default: base_lu = 7'd0;
    endcase
  end

`ifdef PS2_KBMAT_EXT_EN
  always_comb begin
    case (rx_byte)
      8'h75:   ext_lu = {1'b1, 6'd59};
      8'h72:   ext_lu = {1'b1, 6'd58};
      8'h6B:   ext_lu = {1'b1, 6'd57};
      8'h74:   ext_lu = {1'b1, 6'd56};
      default: ext_lu = 7'd0;
    endcase
  end
`else
  // The E0 states still run so the prefixed byte(s) get consumed, but
  // with no extended map they can never touch kbmat.
  assign ext_lu = 7'd0;
`endif

  always_comb begin
    dec_next   = dec_state;
    do_set     = 1'b0;
    do_clr     = 1'b0;
    do_clr_all = 1'b0;
    bit_idx    = base_lu[5:0];
    skip_load  = 1'b0;
    skip_dec   = 1'b0;
    if (rx_valid) begin
      case (dec_state)
        D_BASE: begin
          case (rx_byte)
            8'hF0:               dec_next = D_BRK;
            8'hE0:               dec_next = D_EXT;
            8'hE1:               begin dec_next = D_SKIP; skip_load = 1'b1; end
            8'hAA, 8'h00, 8'hFF: do_clr_all = 1'b1;
            8'hFA, 8'hFE, 8'hEE: ;
            default:             do_set = base_lu[6];
          endcase
        end
        D_BRK: begin
          do_clr   = base_lu[6];
          dec_next = D_BASE;
        end
        D_EXT: begin
          bit_idx = ext_lu[5:0];
          if (rx_byte == 8'hF0) dec_next = D_EXTBRK;
          else begin
            do_set   = ext_lu[6];
            dec_next = D_BASE;
          end
        end
        D_EXTBRK: begin
          bit_idx  = ext_lu[5:0];
          do_clr   = ext_lu[6];
          dec_next = D_BASE;
        end
        D_SKIP: begin
          skip_dec = 1'b1;
          if (skip_cnt == 3'd1) dec_next = D_BASE;
        end
        default: dec_next = D_BASE;
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (res) begin
      dec_state <= D_BASE;
      skip_cnt  <= '0;
      kbmat     <= '0;
    end else begin
      dec_state <= dec_next;
      if (skip_load) skip_cnt <= 3'd7;
      else if (skip_dec) skip_cnt <= skip_cnt - 3'd1;
      if (do_clr_all) kbmat <= '0;
      else if (do_set) kbmat[bit_idx] <= 1'b1;
      else if (do_clr) kbmat[bit_idx] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_kbmat.sv
module tb_ps2_kbmat;
  localparam int FILT_LEN = 8;
  localparam int TIMEOUT  = 9830;
  localparam int H        = 25;

  localparam logic [63:0] ONE = 64'h1;
  localparam logic [63:0] K6  = ONE << 6;
  localparam logic [63:0] K7  = ONE << 7;
  localparam logic [63:0] K36 = ONE << 36;
  localparam logic [63:0] K54 = ONE << 54;
  localparam logic [63:0] K62 = ONE << 62;
  localparam logic [63:0] K63 = ONE << 63;
`ifdef PS2_KBMAT_EXT_EN
  localparam logic [63:0] X58 = ONE << 58;
  localparam logic [63:0] X59 = ONE << 59;
`else
  localparam logic [63:0] X58 = 64'h0;
  localparam logic [63:0] X59 = 64'h0;
`endif

  logic        mck = 1'b0;
  logic        res, ps2_clk, ps2_dat;
  logic [63:0] kbmat;
  logic [7:0]  rx_byte;
  logic        rx_valid, ps2_err;

  ps2_kbmat #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) dut (
    .mck(mck), .res(res), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .kbmat(kbmat), .rx_byte(rx_byte), .rx_valid(rx_valid), .ps2_err(ps2_err)
  );

  always #5 mck = ~mck;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int vcnt = 0;
  int ecnt = 0;
  logic        prev_valid = 1'b0;
  logic [63:0] kb_at_valid = '0;
  logic [63:0] kb_after = '0;

  always @(posedge mck) cyc <= cyc + 1;

  always @(negedge mck) begin
    if (prev_valid) kb_after = kbmat;
    if (rx_valid) begin
      vcnt++;
      kb_at_valid = kbmat;
    end
    if (ps2_err) ecnt++;
    prev_valid = rx_valid;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge mck);
  endtask

  // mode: 0 good, 1 bad parity, 2 bad stop, 3 start bit 1 (single edge)
  task automatic send_frame(input logic [7:0] code, input int mode, input int nbits);
    logic [10:0] b;
    b = {(mode == 2) ? 1'b0 : 1'b1, (~^code) ^ (mode == 1), code, (mode == 3)};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = b[i];
      idle(H);
      ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      idle(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    idle(2 * H);
  endtask

  typedef struct {
    logic [7:0]  code;
    int          mode;
    logic [63:0] kb;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic [7:0] code, input int mode, input logic [63:0] kb);
    vec_t v;
    v.code = code; v.mode = mode; v.kb = kb;
    tv.push_back(v);
  endtask

  initial begin
    int v0, e0, delta;
    logic found;
    res = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
    idle(4);
    res = 1'b0;
    idle(2);
    chk("reset_kbmat", kbmat, 64'h0);
    chk("reset_rx_byte", {56'h0, rx_byte}, 64'h0);
    chk("reset_rx_valid", {63'h0, rx_valid}, 64'h0);
    chk("reset_ps2_err", {63'h0, ps2_err}, 64'h0);

    v0 = vcnt;
    send_frame(8'h1C, 0, 11);
    idle(20);
    chk("first_valid_count", 64'(vcnt - v0), 64'd1);
    chk("first_rx_byte", {56'h0, rx_byte}, 64'h1C);
    chk("first_kb_at_valid", {63'h0, kb_at_valid[36]}, 64'h0);
    chk("first_kb_after_valid", {63'h0, kb_after[36]}, 64'h1);
    chk("first_kbmat", kbmat, K36);

    add(8'h12, 0, K36 | K54);
    add(8'hF0, 0, K36 | K54);
    add(8'h1C, 0, K54);
    add(8'hF0, 0, K54);
    add(8'h12, 0, 64'h0);
    add(8'h1C, 1, 64'h0);
    add(8'h1C, 0, K36);
    add(8'h1C, 2, K36);
    add(8'h00, 3, K36);
    add(8'h29, 0, K36 | K62);
    add(8'h29, 0, K36 | K62);
    add(8'hFA, 0, K36 | K62);
    add(8'hAA, 0, 64'h0);
    add(8'hF0, 0, 64'h0);
    add(8'h29, 0, 64'h0);
    add(8'hE0, 0, 64'h0);
    add(8'h75, 0, X59);
    add(8'hE0, 0, X59);
    add(8'hF0, 0, X59);
    add(8'h75, 0, 64'h0);
    add(8'hE1, 0, 64'h0);
    add(8'h14, 0, 64'h0);
    add(8'h77, 0, 64'h0);
    add(8'hE1, 0, 64'h0);
    add(8'hF0, 0, 64'h0);
    add(8'h14, 0, 64'h0);
    add(8'hF0, 0, 64'h0);
    add(8'h77, 0, 64'h0);
    add(8'h1C, 0, K36);
    add(8'h66, 0, K36 | K7);
    add(8'h5A, 0, K36 | K7 | K6);
    add(8'hE0, 0, K36 | K7 | K6);
    add(8'h72, 0, K36 | K7 | K6 | X58);
    add(8'h59, 0, K36 | K7 | K6 | X58 | K63);
    add(8'hE0, 0, K36 | K7 | K6 | X58 | K63);
    add(8'hF0, 0, K36 | K7 | K6 | X58 | K63);
    add(8'h72, 0, K36 | K7 | K6 | K63);

    foreach (tv[i]) begin
      v0 = vcnt; e0 = ecnt;
      send_frame(tv[i].code, tv[i].mode, (tv[i].mode == 3) ? 1 : 11);
      idle(20);
      chk($sformatf("vec%0d_kbmat", i), kbmat, tv[i].kb);
      chk($sformatf("vec%0d_valid_count", i), 64'(vcnt - v0), (tv[i].mode == 0) ? 64'd1 : 64'd0);
      chk($sformatf("vec%0d_err_count", i), 64'(ecnt - e0), (tv[i].mode == 0) ? 64'd0 : 64'd1);
      if (tv[i].mode == 0)
        chk($sformatf("vec%0d_rx_byte", i), {56'h0, rx_byte}, {56'h0, tv[i].code});
    end

    // Clock stops after 4 data bits.
    v0 = vcnt; e0 = ecnt; found = 1'b0; delta = 0;
    send_frame(8'h29, 0, 5);
    for (int i = 0; i < TIMEOUT + 2000 && !found; i++) begin
      @(negedge mck);
      if (ps2_err) begin
        found = 1'b1;
        delta = cyc - last_fall_cyc;
      end
    end
    chk("timeout_seen", {63'h0, found}, 64'h1);
    chk("timeout_delay_in_window",
        {63'h0, (delta >= TIMEOUT + 2) && (delta <= TIMEOUT + FILT_LEN + 12)}, 64'h1);
    idle(5);
    chk("timeout_err_count", 64'(ecnt - e0), 64'd1);
    chk("timeout_no_valid", 64'(vcnt - v0), 64'd0);
    send_frame(8'h29, 0, 11);
    idle(20);
    chk("after_timeout_kbmat", kbmat, K36 | K7 | K6 | K63 | K62);

    // Reset mid-frame.
    send_frame(8'h12, 0, 4);
    res = 1'b1;
    idle(1);
    res = 1'b0;
    idle(1);
    chk("midreset_kbmat", kbmat, 64'h0);
    chk("midreset_rx_byte", {56'h0, rx_byte}, 64'h0);
    chk("midreset_rx_valid", {63'h0, rx_valid}, 64'h0);
    chk("midreset_ps2_err", {63'h0, ps2_err}, 64'h0);
    v0 = vcnt;
    send_frame(8'h1C, 0, 11);
    idle(20);
    chk("post_reset_valid_count", 64'(vcnt - v0), 64'd1);
    chk("post_reset_rx_byte", {56'h0, rx_byte}, 64'h1C);
    chk("post_reset_kbmat", kbmat, K36);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
